// File: rtl/puf_auth_ctrl.sv
// Ring-oscillator PUF enrollment / authentication controller.
// Runs NUM_SAMPLES timed measurement windows on the PUF, majority-votes every
// response bit, then either stores the vote as the golden response (enroll)
// or compares it to the golden by Hamming distance (authenticate).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, mode       operation request (mode 0 = enroll, 1 = authenticate)
//   puf_enable        measurement enable towards ro_puf_top
//   puf_response      PUF response, captured on the last cycle of each window
//   busy, done        operation in progress / one-cycle result strobe
//   pass, fail        verdict, held until the next accepted start
//   no_enroll         authenticate requested before any enrollment
//   enrolled          golden response is valid
//   hd, voted         Hamming distance of last authenticate, last voted response
module puf_auth_ctrl #(
    parameter int unsigned RESP_W      = 4,
    parameter int unsigned MEAS_CYCLES = 100,
    parameter int unsigned GAP_CYCLES  = 10,
    parameter int unsigned NUM_SAMPLES = 3,
    parameter int unsigned HD_THRESH   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            mode,
    output logic                            puf_enable,
    input  logic [RESP_W-1:0]               puf_response,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic                            fail,
    output logic                            no_enroll,
    output logic                            enrolled,
    output logic [$clog2(RESP_W+1)-1:0]     hd,
    output logic [RESP_W-1:0]               voted
);

    localparam int unsigned HD_W    = $clog2(RESP_W + 1);
    localparam int unsigned VOTE_W  = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned IDX_W   = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int unsigned CYC_MAX = (MEAS_CYCLES > GAP_CYCLES) ? MEAS_CYCLES : GAP_CYCLES;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX);

    localparam logic [CYC_W-1:0]  MEAS_LAST = CYC_W'(MEAS_CYCLES - 1);
    localparam logic [CYC_W-1:0]  GAP_LAST  = CYC_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [VOTE_W-1:0] VOTE_HALF = VOTE_W'(NUM_SAMPLES / 2);
    localparam logic [HD_W-1:0]   HD_MAX    = HD_W'(HD_THRESH);

    typedef enum logic [2:0] {IDLE, MEASURE, GAP, DECIDE, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [CYC_W-1:0]    cyc_cnt;
    logic [IDX_W-1:0]    idx;
    logic [VOTE_W-1:0]   votes [RESP_W];
    logic [RESP_W-1:0]   golden;
    logic                mode_q;
    logic                meas_last;
    logic [RESP_W-1:0]   voted_c;
    logic [HD_W-1:0]     hd_c;
    logic                pass_c;

    assign meas_last = (state == MEASURE) && (cyc_cnt == MEAS_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (!mode || enrolled) ? MEASURE : DONE;
            end
            MEASURE: begin
                if (meas_last) state_next = (idx == IDX_LAST) ? DECIDE : GAP;
            end
            GAP: begin
                if (cyc_cnt == GAP_LAST) state_next = MEASURE;
            end
            DECIDE:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Majority vote and Hamming distance against the golden response
    always_comb begin
        voted_c = '0;
        hd_c    = '0;
        for (int i = 0; i < int'(RESP_W); i++) begin
            voted_c[i] = votes[i] > VOTE_HALF;
            hd_c       = hd_c + HD_W'(golden[i] ^ voted_c[i]);
        end
        pass_c = hd_c <= HD_MAX;
    end

    // Datapath and registered outputs (decoded from the next state so they
    // line up with the state they describe)
    always_ff @(posedge clk) begin
        if (rst) begin
            puf_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            no_enroll  <= 1'b0;
            enrolled   <= 1'b0;
            hd         <= '0;
            voted      <= '0;
            golden     <= '0;
            mode_q     <= 1'b0;
            cyc_cnt    <= '0;
            idx        <= '0;
            for (int i = 0; i < int'(RESP_W); i++) votes[i] <= '0;
        end else begin
            puf_enable <= (state_next == MEASURE);
            busy       <= (state_next == MEASURE) || (state_next == GAP) || (state_next == DECIDE);
            done       <= (state_next == DONE);
            // Window timer restarts on every state change
            cyc_cnt    <= (state_next != state) ? '0 : cyc_cnt + CYC_W'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        pass   <= 1'b0;
                        if (!mode || enrolled) begin
                            fail      <= 1'b0;
                            no_enroll <= 1'b0;
                            idx       <= '0;
                            for (int i = 0; i < int'(RESP_W); i++) votes[i] <= '0;
                        end else begin
                            fail      <= 1'b1;
                            no_enroll <= 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    if (meas_last) begin
                        idx <= idx + IDX_W'(1);
                        for (int i = 0; i < int'(RESP_W); i++)
                            votes[i] <= votes[i] + VOTE_W'(puf_response[i]);
                    end
                end
                DECIDE: begin
                    voted <= voted_c;
                    if (!mode_q) begin
                        golden   <= voted_c;
                        enrolled <= 1'b1;
                        pass     <= 1'b1;
                        fail     <= 1'b0;
                    end else begin
                        hd   <= hd_c;
                        pass <= pass_c;
                        fail <= !pass_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_auth_ctrl.sv
// Scoreboard bench for puf_auth_ctrl: stimulus pushes expected results,
// monitors pop and compare on every done strobe.
module tb_puf_auth_ctrl;

    typedef struct {
        int         done_rel;
        int         en_high;
        int         en_rise;
        int         busy_n;
        logic       pass;
        logic       fail;
        logic       no_enroll;
        logic       enrolled;
        logic [2:0] hd;
        logic [3:0] voted;
        int         start_cyc;
        int         b_high;
        int         b_rise;
        int         b_busy;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic [3:0] puf_response;
    logic       puf_enable, busy, done, pass, fail, no_enroll, enrolled;
    logic [2:0] hd;
    logic [3:0] voted;

    logic       s_start, s_mode;
    logic [3:0] s_resp;
    logic       s_en, s_busy, s_done, s_pass, s_fail, s_ne, s_enrolled;
    logic [2:0] s_hd;
    logic [3:0] s_voted;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   en_high = 0, en_rise = 0, busy_cnt = 0, n_done = 0, n_push = 0;
    logic en_prev = 1'b0;
    exp_t q[$];
    exp_t sq[$];

    puf_auth_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .puf_enable(puf_enable), .puf_response(puf_response),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .no_enroll(no_enroll), .enrolled(enrolled), .hd(hd), .voted(voted)
    );

    puf_auth_ctrl #(.RESP_W(4), .MEAS_CYCLES(2), .GAP_CYCLES(1), .NUM_SAMPLES(1), .HD_THRESH(1)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode),
        .puf_enable(s_en), .puf_response(s_resp),
        .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail),
        .no_enroll(s_ne), .enrolled(s_enrolled), .hd(s_hd), .voted(s_voted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic exp_t mk(input int dr, input int eh, input int er, input int bz,
                                input logic p, input logic f, input logic ne, input logic en,
                                input logic [2:0] h, input logic [3:0] v);
        exp_t e;
        e.done_rel = dr; e.en_high = eh; e.en_rise = er; e.busy_n = bz;
        e.pass = p; e.fail = f; e.no_enroll = ne; e.enrolled = en;
        e.hd = h; e.voted = v;
        e.start_cyc = 0; e.b_high = 0; e.b_rise = 0; e.b_busy = 0;
        return e;
    endfunction

    // Main monitor: activity counters plus scoreboard compare on done
    always @(negedge clk) begin
        exp_t e;
        if (puf_enable) en_high <= en_high + 1;
        if (puf_enable && !en_prev) en_rise <= en_rise + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        en_prev <= puf_enable;
        if (done) begin
            n_done <= n_done + 1;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc - e.start_cyc, e.done_rel);
                chk("en_high_cycles", en_high - e.b_high, e.en_high);
                chk("en_windows", en_rise - e.b_rise, e.en_rise);
                chk("busy_cycles", busy_cnt - e.b_busy, e.busy_n);
                chk("pass", int'(pass), int'(e.pass));
                chk("fail", int'(fail), int'(e.fail));
                chk("no_enroll", int'(no_enroll), int'(e.no_enroll));
                chk("enrolled", int'(enrolled), int'(e.enrolled));
                chk("hd", int'(hd), int'(e.hd));
                chk("voted", int'(voted), int'(e.voted));
            end
        end
    end

    // Monitor for the single-sample instance
    always @(negedge clk) begin
        exp_t e;
        if (s_done) begin
            if (sq.size() == 0) begin
                chk("s_unexpected_done", 1, 0);
            end else begin
                e = sq.pop_front();
                chk("s_done_cycle", cyc - e.start_cyc, e.done_rel);
                chk("s_pass", int'(s_pass), int'(e.pass));
                chk("s_fail", int'(s_fail), int'(e.fail));
                chk("s_enrolled", int'(s_enrolled), int'(e.enrolled));
                chk("s_hd", int'(s_hd), int'(e.hd));
                chk("s_voted", int'(s_voted), int'(e.voted));
            end
        end
    end

    // One operation on the main instance; sample k is driven from the k-th enable rise.
    // With spam set, start is pulsed during the operation (mode forced to 1).
    task automatic run_op(input logic m, input logic [3:0] s0, input logic [3:0] s1,
                          input logic [3:0] s2, input exp_t e, input bit spam);
        logic [3:0] smp [3];
        int   k;
        logic pe;
        smp[0] = s0; smp[1] = s1; smp[2] = s2;
        @(negedge clk);
        start = 1'b1; mode = m; puf_response = s0;
        e.start_cyc = cyc; e.b_high = en_high; e.b_rise = en_rise; e.b_busy = busy_cnt;
        q.push_back(e);
        n_push++;
        k = 0; pe = 1'b0;
        for (int c = 1; c <= 1000 && q.size() != 0; c++) begin
            @(negedge clk);
            start = spam && (c >= 3) && (c <= 300) && (c % 5 == 0);
            mode  = spam ? 1'b1 : m;
            if (puf_enable && !pe) begin
                if (k < 3) puf_response = smp[k];
                k++;
            end
            pe = puf_enable;
        end
        start = 1'b0;
        if (q.size() != 0) begin
            chk("done_timeout", 1, 0);
            q.delete();
        end
    endtask

    task automatic run_small(input logic m, input logic [3:0] s, input exp_t e);
        @(negedge clk);
        s_start = 1'b1; s_mode = m; s_resp = s;
        e.start_cyc = cyc;
        sq.push_back(e);
        for (int c = 0; c < 50 && sq.size() != 0; c++) begin
            @(negedge clk);
            s_start = 1'b0;
        end
        s_start = 1'b0;
        if (sq.size() != 0) begin
            chk("s_done_timeout", 1, 0);
            sq.delete();
        end
    endtask

    initial begin
        int s;
        rst = 1'b1; start = 1'b0; mode = 1'b0; puf_response = 4'b0000;
        s_start = 1'b0; s_mode = 1'b0; s_resp = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_puf_enable", int'(puf_enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_no_enroll", int'(no_enroll), 0);
        chk("rst_enrolled", int'(enrolled), 0);
        chk("rst_hd", int'(hd), 0);
        chk("rst_voted", int'(voted), 0);

        // Authenticate before enrollment
        run_op(1'b1, 4'b1010, 4'b1010, 4'b1010, mk(1, 0, 0, 0, 0, 1, 1, 0, 3'd0, 4'b0000), 1'b0);
        // Enroll constant, then per-bit majority of differing samples
        run_op(1'b0, 4'b1011, 4'b1011, 4'b1011, mk(322, 300, 3, 321, 1, 0, 0, 1, 3'd0, 4'b1011), 1'b0);
        run_op(1'b0, 4'b1011, 4'b0011, 4'b1001, mk(322, 300, 3, 321, 1, 0, 0, 1, 3'd0, 4'b1011), 1'b0);
        // Authenticate near and far from golden 1011
        run_op(1'b1, 4'b1010, 4'b1010, 4'b1010, mk(322, 300, 3, 321, 1, 0, 0, 1, 3'd1, 4'b1010), 1'b0);
        run_op(1'b1, 4'b0100, 4'b0100, 4'b0100, mk(322, 300, 3, 321, 0, 1, 0, 1, 3'd4, 4'b0100), 1'b0);
        // Re-enroll with start pulsed mid-operation; hd is held from before
        run_op(1'b0, 4'b0110, 4'b0110, 4'b0110, mk(322, 300, 3, 321, 1, 0, 0, 1, 3'd4, 4'b0110), 1'b1);
        repeat (30) @(negedge clk);
        chk("single_done", n_done, n_push);

        // Reset in the middle of an authenticate
        @(negedge clk);
        start = 1'b1; mode = 1'b1; puf_response = 4'b1011;
        s = cyc;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_rel_cycle", cyc - s, 150);
        chk("pre_rst_puf_enable", int'(puf_enable), 1);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_puf_enable", int'(puf_enable), 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_enrolled", int'(enrolled), 0);
        chk("post_rst_done", int'(done), 0);
        repeat (400) @(negedge clk);
        chk("no_done_after_rst", n_done, n_push);
        // Enrollment was lost
        run_op(1'b1, 4'b1011, 4'b1011, 4'b1011, mk(1, 0, 0, 0, 0, 1, 1, 0, 3'd0, 4'b0000), 1'b0);

        // Single-sample instance: 2-cycle window, done in cycle 4
        run_small(1'b0, 4'b0110, mk(4, 2, 1, 3, 1, 0, 0, 1, 3'd0, 4'b0110));
        run_small(1'b1, 4'b0111, mk(4, 2, 1, 3, 1, 0, 0, 1, 3'd1, 4'b0111));
        run_small(1'b1, 4'b1001, mk(4, 2, 1, 3, 0, 1, 0, 1, 3'd4, 4'b1001));

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
